// File: rtl/calc2_port_req_driver.sv
// rtl/calc2_port_req_driver.sv - calc2 port request driver: tag allocation, two-cycle issue,
// response matching, ageing and timeout reporting.
module calc2_port_req_driver #(
  parameter int CALC_CMD_WIDTH  = 4,
  parameter int CALC_DATA_WIDTH = 32,
  parameter int TIMEOUT         = 100
) (
  input  logic                       PClk,
  input  logic                       Rst,
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic [CALC_CMD_WIDTH-1:0]  op_cmd,
  input  logic [CALC_DATA_WIDTH-1:0] op_data1,
  input  logic [CALC_DATA_WIDTH-1:0] op_data2,
  output logic [CALC_CMD_WIDTH-1:0]  req_cmd,
  output logic [CALC_DATA_WIDTH-1:0] req_data,
  output logic [1:0]                 req_tag,
  input  logic [1:0]                 out_resp,
  input  logic [CALC_DATA_WIDTH-1:0] out_data,
  input  logic [1:0]                 out_tag,
  output logic                       cpl_valid,
  output logic [CALC_CMD_WIDTH-1:0]  cpl_cmd,
  output logic [1:0]                 cpl_tag,
  output logic [1:0]                 cpl_resp,
  output logic [CALC_DATA_WIDTH-1:0] cpl_data,
  output logic                       tmo_valid,
  output logic [1:0]                 tmo_tag,
  output logic                       err_unexp,
  output logic [2:0]                 outstanding
);

  typedef enum logic [1:0] {IDLE, SEND1, SEND2} state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t                     state, state_next;
  logic [3:0]                 busy, busy_next;
  logic [7:0]                 age [4];
  logic [CALC_CMD_WIDTH-1:0]  cmd_mem [4];
  logic [CALC_CMD_WIDTH-1:0]  cur_cmd;
  logic [CALC_DATA_WIDTH-1:0] cur_data1, cur_data2;
  logic [1:0]                 cur_tag;
  logic [1:0]                 alloc_tag;
  logic                       accept, issue;
  logic                       resp_hit, resp_unexp;
  logic [3:0]                 pending;
  logic                       tmo_any;
  logic [1:0]                 tmo_pick;

  assign op_ready   = (state == IDLE || state == SEND2) && !Rst && (busy != 4'b1111);
  assign accept     = op_valid && op_ready;
  assign issue      = accept && (op_cmd != '0);
  assign resp_hit   = (out_resp != 2'd0) && busy[out_tag];
  assign resp_unexp = (out_resp != 2'd0) && !busy[out_tag];

  always_comb begin
    alloc_tag = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!busy[i]) alloc_tag = 2'(i);
    end
  end

  // A tag answered this cycle is never also timed out: the response wins.
  always_comb begin
    pending  = '0;
    tmo_pick = 2'd0;
    for (int i = 0; i < 4; i++) begin
      pending[i] = busy[i] && (age[i] == TMO) && !(resp_hit && (out_tag == 2'(i)));
    end
    for (int i = 3; i >= 0; i--) begin
      if (pending[i]) tmo_pick = 2'(i);
    end
    tmo_any = |pending;
  end

  always_comb begin
    busy_next = busy;
    if (resp_hit) busy_next[out_tag] = 1'b0;
    if (tmo_any)  busy_next[tmo_pick] = 1'b0;
    if (issue)    busy_next[alloc_tag] = 1'b1;
  end

  always_ff @(posedge PClk) begin
    if (Rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = issue ? SEND1 : IDLE;
      SEND1:   state_next = SEND2;
      SEND2:   state_next = issue ? SEND1 : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_cmd  = '0;
    req_data = '0;
    req_tag  = 2'd0;
    case (state)
      SEND1: begin
        req_cmd  = cur_cmd;
        req_data = cur_data1;
        req_tag  = cur_tag;
      end
      SEND2: begin
        req_data = cur_data2;
        req_tag  = cur_tag;
      end
      default: ;
    endcase
  end

  always_ff @(posedge PClk) begin
    if (Rst) begin
      busy        <= '0;
      outstanding <= 3'd0;
      cur_cmd     <= '0;
      cur_data1   <= '0;
      cur_data2   <= '0;
      cur_tag     <= 2'd0;
      cpl_valid   <= 1'b0;
      cpl_cmd     <= '0;
      cpl_tag     <= 2'd0;
      cpl_resp    <= 2'd0;
      cpl_data    <= '0;
      tmo_valid   <= 1'b0;
      tmo_tag     <= 2'd0;
      err_unexp   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        age[i]     <= 8'd0;
        cmd_mem[i] <= '0;
      end
    end else begin
      busy        <= busy_next;
      outstanding <= {2'b0, busy_next[0]} + {2'b0, busy_next[1]}
                   + {2'b0, busy_next[2]} + {2'b0, busy_next[3]};
      if (issue) begin
        cur_cmd            <= op_cmd;
        cur_data1          <= op_data1;
        cur_data2          <= op_data2;
        cur_tag            <= alloc_tag;
        cmd_mem[alloc_tag] <= op_cmd;
      end
      for (int i = 0; i < 4; i++) begin
        if (issue && (alloc_tag == 2'(i)))  age[i] <= 8'd0;
        else if (busy[i] && (age[i] != TMO)) age[i] <= age[i] + 8'd1;
      end
      cpl_valid <= resp_hit;
      if (resp_hit) begin
        cpl_cmd  <= cmd_mem[out_tag];
        cpl_tag  <= out_tag;
        cpl_resp <= out_resp;
        cpl_data <= out_data;
      end
      err_unexp <= resp_unexp;
      tmo_valid <= tmo_any;
      if (tmo_any) tmo_tag <= tmo_pick;
    end
  end

endmodule

// File: tb/tb_calc2_port_req_driver.sv
// tb/tb_calc2_port_req_driver.sv - directed bench for calc2_port_req_driver with TIMEOUT=10.
module tb_calc2_port_req_driver;

  logic        PClk;
  logic        Rst;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  op_cmd;
  logic [31:0] op_data1, op_data2;
  logic [3:0]  req_cmd;
  logic [31:0] req_data;
  logic [1:0]  req_tag;
  logic [1:0]  out_resp;
  logic [31:0] out_data;
  logic [1:0]  out_tag;
  logic        cpl_valid;
  logic [3:0]  cpl_cmd;
  logic [1:0]  cpl_tag;
  logic [1:0]  cpl_resp;
  logic [31:0] cpl_data;
  logic        tmo_valid;
  logic [1:0]  tmo_tag;
  logic        err_unexp;
  logic [2:0]  outstanding;

  int total = 0;
  int bad   = 0;

  calc2_port_req_driver #(
    .CALC_CMD_WIDTH (4),
    .CALC_DATA_WIDTH(32),
    .TIMEOUT        (10)
  ) dut (
    .PClk       (PClk),
    .Rst        (Rst),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_cmd     (op_cmd),
    .op_data1   (op_data1),
    .op_data2   (op_data2),
    .req_cmd    (req_cmd),
    .req_data   (req_data),
    .req_tag    (req_tag),
    .out_resp   (out_resp),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .cpl_valid  (cpl_valid),
    .cpl_cmd    (cpl_cmd),
    .cpl_tag    (cpl_tag),
    .cpl_resp   (cpl_resp),
    .cpl_data   (cpl_data),
    .tmo_valid  (tmo_valid),
    .tmo_tag    (tmo_tag),
    .err_unexp  (err_unexp),
    .outstanding(outstanding)
  );

  initial PClk = 1'b0;
  always #5 PClk = ~PClk;

  task automatic tick();
    @(posedge PClk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  initial begin
    int cnt;
    int t0_cyc, t1_cyc;
    logic [1:0] t0_tag, t1_tag;

    Rst = 1'b1; op_valid = 1'b0; op_cmd = '0; op_data1 = '0; op_data2 = '0;
    out_resp = 2'd0; out_data = '0; out_tag = 2'd0;
    tick(); tick();
    chk("rst_op_ready", {31'b0, op_ready}, 0);
    chk("rst_outstanding", {29'b0, outstanding}, 0);
    chk("rst_req_cmd", {28'b0, req_cmd}, 0);
    chk("rst_cpl_valid", {31'b0, cpl_valid}, 0);
    chk("rst_tmo_valid", {31'b0, tmo_valid}, 0);
    chk("rst_err_unexp", {31'b0, err_unexp}, 0);
    Rst = 1'b0;
    #1;
    chk("idle_op_ready", {31'b0, op_ready}, 1);

    // single add(1) 5,7 -> 12
    op_valid = 1'b1; op_cmd = 4'd1; op_data1 = 32'd5; op_data2 = 32'd7;
    tick();
    op_valid = 1'b0;
    chk("s1_req_cmd", {28'b0, req_cmd}, 1);
    chk("s1_req_data", req_data, 5);
    chk("s1_req_tag", {30'b0, req_tag}, 0);
    chk("s1_op_ready", {31'b0, op_ready}, 0);
    chk("s1_outstanding", {29'b0, outstanding}, 1);
    tick();
    chk("s2_req_cmd", {28'b0, req_cmd}, 0);
    chk("s2_req_data", req_data, 7);
    chk("s2_req_tag", {30'b0, req_tag}, 0);
    out_resp = 2'd1; out_data = 32'd12; out_tag = 2'd0;
    tick();
    out_resp = 2'd0;
    chk("c1_cpl_valid", {31'b0, cpl_valid}, 1);
    chk("c1_cpl_cmd", {28'b0, cpl_cmd}, 1);
    chk("c1_cpl_data", cpl_data, 12);
    chk("c1_cpl_tag", {30'b0, cpl_tag}, 0);
    chk("c1_cpl_resp", {30'b0, cpl_resp}, 1);
    chk("c1_outstanding", {29'b0, outstanding}, 0);
    chk("c1_req_cmd_idle", {28'b0, req_cmd}, 0);
    tick();
    chk("c1_cpl_valid_drop", {31'b0, cpl_valid}, 0);
    chk("c1_cpl_data_hold", cpl_data, 12);

    // four back-to-back ops fill tags 0..3
    for (int i = 0; i < 4; i++) begin
      op_valid = 1'b1; op_cmd = 4'd2; op_data1 = 32'h10 + i; op_data2 = 32'h20 + i;
      tick();
      chk("b2b_s1_tag", {30'b0, req_tag}, i);
      chk("b2b_s1_cmd", {28'b0, req_cmd}, 2);
      chk("b2b_s1_data", req_data, 32'h10 + i);
      tick();
      chk("b2b_s2_data", req_data, 32'h20 + i);
    end
    chk("full_op_ready", {31'b0, op_ready}, 0);
    chk("full_outstanding", {29'b0, outstanding}, 4);
    op_cmd = 4'd3; op_data1 = 32'h55; op_data2 = 32'h66;
    tick();
    chk("full_idle_req_cmd", {28'b0, req_cmd}, 0);
    chk("full_still_blocked", {31'b0, op_ready}, 0);
    out_resp = 2'd2; out_data = 32'h99; out_tag = 2'd2;
    tick();
    out_resp = 2'd0;
    chk("t2_cpl_valid", {31'b0, cpl_valid}, 1);
    chk("t2_cpl_tag", {30'b0, cpl_tag}, 2);
    chk("t2_cpl_cmd", {28'b0, cpl_cmd}, 2);
    chk("t2_cpl_resp", {30'b0, cpl_resp}, 2);
    chk("t2_cpl_data", cpl_data, 32'h99);
    chk("t2_outstanding", {29'b0, outstanding}, 3);
    chk("t2_op_ready", {31'b0, op_ready}, 1);
    tick();
    op_valid = 1'b0;
    chk("fifth_req_tag", {30'b0, req_tag}, 2);
    chk("fifth_req_cmd", {28'b0, req_cmd}, 3);
    chk("fifth_req_data", req_data, 32'h55);
    chk("fifth_outstanding", {29'b0, outstanding}, 4);

    // reset while in SEND1
    Rst = 1'b1;
    tick();
    chk("midrst_req_cmd", {28'b0, req_cmd}, 0);
    chk("midrst_outstanding", {29'b0, outstanding}, 0);
    chk("midrst_op_ready", {31'b0, op_ready}, 0);
    chk("midrst_tmo_valid", {31'b0, tmo_valid}, 0);
    Rst = 1'b0;
    tick();
    chk("midrst_no_send2_data", req_data, 0);
    chk("midrst_ready_again", {31'b0, op_ready}, 1);

    // response on a tag that is not outstanding
    out_resp = 2'd1; out_data = 32'h77; out_tag = 2'd3;
    tick();
    out_resp = 2'd0;
    chk("unexp_err", {31'b0, err_unexp}, 1);
    chk("unexp_cpl_valid", {31'b0, cpl_valid}, 0);
    chk("unexp_outstanding", {29'b0, outstanding}, 0);
    tick();
    chk("unexp_err_drop", {31'b0, err_unexp}, 0);

    // op_cmd==0 is swallowed
    op_valid = 1'b1; op_cmd = 4'd0; op_data1 = 32'hAA; op_data2 = 32'hBB;
    tick();
    op_valid = 1'b0;
    chk("nop_req_cmd", {28'b0, req_cmd}, 0);
    chk("nop_req_data", req_data, 0);
    chk("nop_outstanding", {29'b0, outstanding}, 0);
    chk("nop_op_ready", {31'b0, op_ready}, 1);

    // timeouts: tag 0 at edge 0, tag 1 at edge 2, TIMEOUT=10 -> reports at 11 and 13
    op_valid = 1'b1; op_cmd = 4'd4; op_data1 = 32'd1; op_data2 = 32'd2;
    tick();
    op_cmd = 4'd5; op_data1 = 32'd3; op_data2 = 32'd4;
    tick();
    tick();
    op_valid = 1'b0;
    chk("tmo_second_tag", {30'b0, req_tag}, 1);
    cnt = 2; t0_cyc = -1; t1_cyc = -1; t0_tag = 2'd3; t1_tag = 2'd3;
    while (cnt < 25) begin
      tick();
      cnt++;
      if (tmo_valid) begin
        if (t0_cyc < 0) begin t0_cyc = cnt; t0_tag = tmo_tag; end
        else if (t1_cyc < 0) begin t1_cyc = cnt; t1_tag = tmo_tag; end
      end
    end
    chk("tmo_first_cycle", t0_cyc, 11);
    chk("tmo_first_tag", {30'b0, t0_tag}, 0);
    chk("tmo_second_cycle", t1_cyc, 13);
    chk("tmo_second_tag", {30'b0, t1_tag}, 1);
    chk("tmo_outstanding", {29'b0, outstanding}, 0);
    out_resp = 2'd1; out_data = 32'h5; out_tag = 2'd0;
    tick();
    out_resp = 2'd0;
    chk("late_err_unexp", {31'b0, err_unexp}, 1);
    chk("late_cpl_valid", {31'b0, cpl_valid}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
